// File: rtl/bcd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_pkg : shared BCD widths, digit type and sequencer states     |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_digit_add : one-digit BCD adder with decimal carry correction|
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [DIGIT_W:0] w_raw;
  logic [DIGIT_W:0] w_adj;

  always_comb begin
    w_raw = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    w_adj = w_raw - (DIGIT_W+1)'(10);
    if (w_raw > (DIGIT_W+1)'(BCD_MAX)) begin
      sum  = w_adj[DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      sum  = w_raw[DIGIT_W-1:0];
      cout = 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/comp.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | comp : 9's complement of one BCD digit (input must be 0..9)      |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module comp
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);
  assign dout = DIGIT_W'(BCD_MAX) - din;
endmodule
`default_nettype wire

// File: rtl/bcd_sub_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_sub_seq : digit-serial |A-B| with sign, via 10's complement  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] result,
  output logic                      neg,
  output logic                      err
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] c_LAST_IDX = IW'(DIGITS - 1);

  state_t                  r_state;
  state_t                  w_next;
  bcd_digit_t [DIGITS-1:0] r_a;
  bcd_digit_t [DIGITS-1:0] r_b;
  bcd_digit_t [DIGITS-1:0] r_res;
  logic [IW-1:0]           r_idx;
  logic                    r_carry;
  logic                    w_bad;
  logic                    w_last;
  bcd_digit_t              w_comp_in;
  bcd_digit_t              w_comp_out;
  bcd_digit_t              w_add_x;
  bcd_digit_t              w_sum;
  logic                    w_cout;

  assign result = r_res;
  assign w_last = (r_idx == c_LAST_IDX);

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((a[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
          (b[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)))
        w_bad = 1'b1;
    end
  end

  // Complementer input is forced to 0 outside SUB/FIX so a captured
  // invalid digit can never reach it.
  always_comb begin
    w_comp_in = '0;
    w_add_x   = '0;
    if (r_state == SUB) begin
      w_comp_in = r_b[r_idx];
      w_add_x   = r_a[r_idx];
    end else if (r_state == FIX) begin
      w_comp_in = r_res[r_idx];
    end
  end

  comp u_comp (
    .din  (w_comp_in),
    .dout (w_comp_out)
  );

  bcd_digit_add u_add (
    .x    (w_add_x),
    .y    (w_comp_out),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_bad ? DONE : SUB;
      SUB:  if (w_last) w_next = w_cout ? DONE : FIX;
      FIX:  if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SUB) || (r_state == FIX);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      neg     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            neg     <= 1'b0;
            err     <= w_bad;
            r_idx   <= '0;
            r_carry <= 1'b1;
          end
        end
        SUB: begin
          r_res[r_idx] <= w_sum;
          if (w_last) begin
            // No final carry means A < B; FIX restarts with carry-in 1.
            r_idx   <= '0;
            r_carry <= 1'b1;
            neg     <= ~w_cout;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_carry <= w_cout;
          end
        end
        FIX: begin
          r_res[r_idx] <= w_sum;
          r_carry      <= w_cout;
          r_idx        <= w_last ? '0 : r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_bcd_sub_seq : random + directed check against decimal model   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_bcd_sub_seq;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, err;
  logic [W-1:0] result;

  int           n_checks = 0;
  int           n_fail = 0;
  bit           pend = 1'b0;
  int           lat = 0;
  logic [W-1:0] exp_res;
  logic         exp_neg, exp_err;
  int           exp_lat;

  bcd_sub_seq #(.DIGITS(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int k = 0; k < D; k++) begin
      r[k*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 1'b0;
    for (int k = 0; k < D; k++) if (v[k*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb2);
    int diff;
    @(negedge clk);
    if (has_bad(ta) || has_bad(tb2)) begin
      exp_err = 1'b1; exp_neg = 1'b0; exp_res = '0; exp_lat = 1;
    end else begin
      diff    = bcd2int(ta) - bcd2int(tb2);
      exp_err = 1'b0;
      exp_neg = (diff < 0);
      exp_res = int2bcd(diff < 0 ? -diff : diff);
      exp_lat = (diff < 0) ? 2 * D + 1 : D + 1;
    end
    a = ta; b = tb2; start = 1'b1;
    lat = 0; pend = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && pend; i++) @(negedge clk);
    n_checks++;
    if (pend) begin
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
      pend = 1'b0;
    end
  endtask

  // Per-cycle compare against the model expectation of the pending operation
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        chk("comp_in_range", 32'(dut.w_comp_in <= 4'd9), 32'd1);
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        chk("busy", 32'(busy), 32'(pend && !done));
        if (pend) lat++;
        if (done) begin
          chk("done_expected", 32'(pend), 32'd1);
          if (pend) begin
            chk("result", 32'(result), 32'(exp_res));
            chk("neg", 32'(neg), 32'(exp_neg));
            chk("err", 32'(err), 32'(exp_err));
            chk("latency", 32'(lat), 32'(exp_lat));
            pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    launch(16'h5432, 16'h1234); wait_done();
    chk("lit_5432_1234", 32'(result), 32'h4198);
    chk("lit_5432_1234_neg", 32'(neg), 32'd0);
    launch(16'h1234, 16'h5432); wait_done();
    chk("lit_1234_5432", 32'(result), 32'h4198);
    chk("lit_1234_5432_neg", 32'(neg), 32'd1);
    launch(16'h0000, 16'h9999); wait_done();
    chk("lit_0_9999", 32'(result), 32'h9999);
    chk("lit_0_9999_neg", 32'(neg), 32'd1);
    launch(16'h7777, 16'h7777); wait_done();
    chk("lit_equal", 32'(result), 32'h0000);
    chk("lit_equal_neg", 32'(neg), 32'd0);
    launch(16'h00A0, 16'h0001); wait_done();
    chk("lit_bad_err", 32'(err), 32'd1);
    chk("lit_bad_result", 32'(result), 32'd0);

    // New start while SUB is running must be ignored
    launch(16'h8000, 16'h0001);
    @(negedge clk);
    a = 16'h1111; b = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("lit_ignore_start", 32'(result), 32'h7999);

    // Reset during FIX aborts with no done
    launch(16'h1234, 16'h5432);
    repeat (5) @(negedge clk);
    rst = 1'b1; pend = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(16'h0100, 16'h0001); wait_done();
    chk("lit_after_abort", 32'(result), 32'h0099);
    chk("lit_after_abort_neg", 32'(neg), 32'd0);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < D; k++) begin
        ra[k*4 +: 4] = 4'($urandom_range(0, 9));
        rb[k*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) ra[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb = ra;
      launch(ra, rb); wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
